dmem_bridge: RTL and testbench

- Sits directly downstream of the mem stage, between its data-RAM port (ce/we/sel/addr/data) and the system data bus.
- Turns the mem stage's single-cycle combinational access into a registered request/acknowledge bus transaction.
- Raises a stall request to the pipeline controller until the access completes, then returns the read word to the mem stage.
- Handles wait states, zero-byte-enable stores and bus timeouts.

---
 rtl/dmem_bridge_pkg.sv | 21 ++
 rtl/dmem_bridge_if.sv | 22 ++
 rtl/dmem_bridge.sv | 122 ++++++++++++
 tb/tb_dmem_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the mem-stage to data-bus bridge.
// The access qualifier lives here so every user agrees on what counts as a real access.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic        RST_ENABLE   = 1'b1;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    // A store with no byte enables is a misaligned store and never reaches the bus.
    function automatic logic is_real_access(input logic ce, input logic we, input logic [3:0] sel);
        return (ce == CHIP_ENABLE) && ((we != WRITE_ENABLE) || (sel != 4'b0000));
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/acknowledge system data bus as seen by the bridge (master) and the bus (slave).
interface dmem_bridge_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );

endinterface

// File: rtl/dmem_bridge.sv
// Converts the mem stage's single-cycle RAM access into a registered req/ack bus
// transaction, stalling the pipeline until it completes or times out.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_ce_i,
    input  logic         mem_we_i,
    input  logic [3:0]   mem_sel_i,
    input  logic [31:0]  mem_addr_i,
    input  logic [31:0]  mem_data_i,
    input  logic         stall_i,
    output logic [31:0]  mem_data_o,
    output logic         stallreq_o,
    output logic         bus_err_o,
    dmem_bridge_if.master bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            stallreq;

    // Ack wins over a coinciding timeout; the error pulse is a single cycle by default-clear.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        stallreq = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_real_access(mem_ce_i, mem_we_i, mem_sel_i)) begin
                    stallreq = !rst;
                    state_d  = REQ;
                    req_d    = 1'b1;
                    we_d     = mem_we_i;
                    sel_d    = mem_sel_i;
                    addr_d   = mem_addr_i;
                    wdata_d  = mem_data_i;
                    cnt_d    = '0;
                end
            end
            REQ: begin
                stallreq = 1'b1;
                if (bus.bus_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata_i;
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = ZERO_WORD;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Holding here while stalled keeps the same instruction from being reissued.
                if (!stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            addr_q  <= ZERO_WORD;
            wdata_q <= ZERO_WORD;
            rdata_q <= ZERO_WORD;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stallreq_o      = stallreq;
    assign mem_data_o      = rdata_q;
    assign bus_err_o       = err_q;
    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: table of single transactions plus hand-written
// sequences for DONE-hold under stall and reset in the middle of a request.
module tb_dmem_bridge;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        stall_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        bus_err_o;

    int assertCount = 0;
    int failCount   = 0;

    dmem_bridge_if bus ();

    dmem_bridge #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_sel_i  (mem_sel_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .stall_i    (stall_i),
        .mem_data_o (mem_data_o),
        .stallreq_o (stallreq_o),
        .bus_err_o  (bus_err_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          ackAt;
        int          expStall;
        int          expReq;
        int          expErr;
        logic [31:0] expMem;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One complete transaction: drive, walk REQ cycles (acking at ackAt), check DONE, return to IDLE.
    task automatic applyStimulus(input vec_t v);
        int stallCnt = 0;
        int reqCnt   = 0;
        int errCnt   = 0;
        int busBad   = 0;
        bit finished = 0;
        mem_ce_i      = v.ce;
        mem_we_i      = v.we;
        mem_sel_i     = v.sel;
        mem_addr_i    = v.addr;
        mem_data_i    = v.data;
        stall_i       = 1'b0;
        bus.bus_ack_i = 1'b0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            #3;
            if (bus_err_o) errCnt++;
            if (bus.bus_req_o) begin
                reqCnt++;
                if (bus.bus_we_o !== v.we || bus.bus_sel_o !== v.sel ||
                    bus.bus_addr_o !== v.addr || bus.bus_wdata_o !== v.data) busBad++;
            end
            if (stallreq_o) stallCnt++;
            else finished = 1;
            if (!finished) begin
                bus.bus_ack_i   = bus.bus_req_o && (v.ackAt != 0) && (reqCnt == v.ackAt);
                bus.bus_rdata_i = v.rdata;
                if (cyc > 0) begin
                    mem_addr_i = $urandom;
                    mem_data_i = $urandom;
                end
                tick();
            end
        end
        if (!finished) begin
            checkOutput({v.name, " completion within budget"}, 32'(finished), 32'd1);
        end
        checkOutput({v.name, " mem_data_o"}, mem_data_o, v.expMem);
        checkOutput({v.name, " stall cycles"}, 32'(stallCnt), 32'(v.expStall));
        checkOutput({v.name, " req cycles"}, 32'(reqCnt), 32'(v.expReq));
        checkOutput({v.name, " bus hold"}, 32'(busBad), 32'd0);
        bus.bus_ack_i = 1'b0;
        mem_ce_i      = 1'b0;
        tick();
        #3;
        if (bus_err_o) errCnt++;
        checkOutput({v.name, " idle req"}, 32'(bus.bus_req_o), 32'd0);
        checkOutput({v.name, " err pulses"}, 32'(errCnt), 32'(v.expErr));
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"zw_load",   1'b1, 1'b0, 4'hF,    32'h100, 32'h0,        32'hDEADBEEF, 1, 2, 1, 0, 32'hDEADBEEF};
        vecs[1] = '{"ws_store",  1'b1, 1'b1, 4'b0100, 32'h202, 32'h77777777, 32'h0BADF00D, 3, 4, 3, 0, 32'hDEADBEEF};
        vecs[2] = '{"mis_store", 1'b1, 1'b1, 4'b0000, 32'h203, 32'h11111111, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF};
        vecs[3] = '{"ws_load",   1'b1, 1'b0, 4'b0011, 32'h044, 32'h0,        32'h12345678, 2, 3, 2, 0, 32'h12345678};
        vecs[4] = '{"timeout",   1'b1, 1'b0, 4'hF,    32'h400, 32'h0,        32'h99999999, 0, 5, 4, 1, 32'h00000000};
        vecs[5] = '{"ack_at_to", 1'b1, 1'b0, 4'hF,    32'h404, 32'h0,        32'hCAFEF00D, 4, 5, 4, 0, 32'hCAFEF00D};
        vecs[6] = '{"zw_store",  1'b1, 1'b1, 4'hF,    32'h300, 32'hA5A5A5A5, 32'h0,        1, 2, 1, 0, 32'hCAFEF00D};
        vecs[7] = '{"no_ce",     1'b0, 1'b0, 4'hF,    32'h500, 32'h0,        32'h0,        0, 0, 0, 0, 32'hCAFEF00D};

        // Reset with a load already presented: stallreq_o must stay low while resetting in IDLE.
        rst             = 1'b1;
        mem_ce_i        = 1'b1;
        mem_we_i        = 1'b0;
        mem_sel_i       = 4'hF;
        mem_addr_i      = 32'h10;
        mem_data_i      = 32'h0;
        stall_i         = 1'b0;
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
        tick();
        #3;
        checkOutput("reset stallreq", 32'(stallreq_o), 32'd0);
        checkOutput("reset bus_req", 32'(bus.bus_req_o), 32'd0);
        checkOutput("reset bus_err", 32'(bus_err_o), 32'd0);
        checkOutput("reset bus_sel", 32'(bus.bus_sel_o), 32'd0);
        checkOutput("reset bus_addr", bus.bus_addr_o, 32'h0);
        checkOutput("reset mem_data", mem_data_o, 32'h0);
        mem_ce_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // DONE held by stall_i for two cycles, then a new load follows.
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h80;
        stall_i    = 1'b0;
        #3;
        checkOutput("hold idle stallreq", 32'(stallreq_o), 32'd1);
        tick();
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h11112222;
        #3;
        checkOutput("hold req1", 32'(bus.bus_req_o), 32'd1);
        tick();
        bus.bus_ack_i = 1'b0;
        stall_i       = 1'b1;
        #3;
        checkOutput("hold done stallreq", 32'(stallreq_o), 32'd0);
        checkOutput("hold done data", mem_data_o, 32'h11112222);
        tick();
        #3;
        checkOutput("hold stalled req a", 32'(bus.bus_req_o), 32'd0);
        checkOutput("hold stalled stallreq", 32'(stallreq_o), 32'd0);
        tick();
        #3;
        checkOutput("hold stalled req b", 32'(bus.bus_req_o), 32'd0);
        stall_i = 1'b0;
        tick();
        mem_addr_i = 32'h84;
        #3;
        checkOutput("release idle stallreq", 32'(stallreq_o), 32'd1);
        checkOutput("release idle req", 32'(bus.bus_req_o), 32'd0);
        tick();
        #3;
        checkOutput("second req", 32'(bus.bus_req_o), 32'd1);
        checkOutput("second addr", bus.bus_addr_o, 32'h84);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h55AA55AA;
        tick();
        bus.bus_ack_i = 1'b0;
        mem_ce_i      = 1'b0;
        #3;
        checkOutput("second data", mem_data_o, 32'h55AA55AA);
        tick();

        // Reset in the second REQ cycle, then a late ack that must be ignored.
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h90;
        tick();
        tick();
        rst = 1'b1;
        #3;
        checkOutput("rst mid req before", 32'(bus.bus_req_o), 32'd1);
        tick();
        rst             = 1'b0;
        mem_ce_i        = 1'b0;
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'hFFFFFFFF;
        #3;
        checkOutput("rst mid req after", 32'(bus.bus_req_o), 32'd0);
        checkOutput("rst mid stallreq", 32'(stallreq_o), 32'd0);
        checkOutput("rst mid err", 32'(bus_err_o), 32'd0);
        checkOutput("rst mid data", mem_data_o, 32'h0);
        tick();
        bus.bus_ack_i = 1'b0;
        #3;
        checkOutput("late ack err", 32'(bus_err_o), 32'd0);
        checkOutput("late ack data", mem_data_o, 32'h0);
        checkOutput("late ack req", 32'(bus.bus_req_o), 32'd0);
        checkOutput("late ack stallreq", 32'(stallreq_o), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
